// File: rtl/qei_multimode.sv
// Quadrature encoder interface: synchronised and filtered A/B/I inputs, x1/x2/x4 decode,
// index capture/zeroing, preload, illegal-transition flag and windowed velocity.
`timescale 1ns/1ps
module qei_multimode #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned FILT_LEN = 3,
    parameter int unsigned WIN_CYC  = 1024,
    parameter int unsigned VEL_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_i,
    input  logic [1:0]       mode,
    input  logic             idx_zero_en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             status_clr,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic [CNT_W-1:0] idx_cnt,
    output logic             idx_seen,
    output logic             err,
    output logic [VEL_W-1:0] vel,
    output logic             vel_valid
);

    localparam int unsigned FCW   = $clog2(FILT_LEN + 1);
    localparam int unsigned ARM_N = FILT_LEN + 3;
    localparam int unsigned AW    = $clog2(ARM_N + 1);
    localparam int unsigned WW    = $clog2(WIN_CYC);

    localparam logic signed [VEL_W-1:0] VMAX = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W-1:0] VMIN = -VMAX;
    localparam logic signed [VEL_W-1:0] VONE = 1;

    typedef enum logic [1:0] {
        MODE_X4  = 2'b00,
        MODE_X2  = 2'b01,
        MODE_X1  = 2'b10,
        MODE_X4B = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        TR_NONE,
        TR_FWD,
        TR_BWD,
        TR_ILL
    } trans_t;

    // bit 2 = A, bit 1 = B, bit 0 = I
    logic [2:0]           sync1, sync2, filt, prev;
    logic [FCW-1:0]       fcnt [3];
    logic [AW-1:0]        arm_cnt;
    logic [WW-1:0]        wcnt;
    logic signed [VEL_W-1:0] delta, delta_nxt;

    trans_t               trans;
    logic                 counted;
    logic                 armed;
    logic                 stp_fwd, stp_bwd, ill, idx_ev, win_end;
    logic [CNT_W-1:0]     count_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            prev  <= '0;
            for (int unsigned i = 0; i < 3; i++) fcnt[i] <= '0;
        end else begin
            sync1 <= {enc_a, enc_b, enc_i};
            sync2 <= sync1;
            prev  <= filt;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (fcnt[i] == FCW'(FILT_LEN - 1)) begin
                        filt[i] <= sync2[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + FCW'(1);
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    assign armed   = (arm_cnt == AW'(ARM_N));
    assign win_end = (wcnt == WW'(WIN_CYC - 1));

    always_comb begin
        trans = TR_NONE;
        case ({prev[2:1], filt[2:1]})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: trans = TR_FWD;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: trans = TR_BWD;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: trans = TR_ILL;
            default:                            trans = TR_NONE;
        endcase

        counted = 1'b1;
        case (mode_t'(mode))
            MODE_X2: counted = prev[2] ^ filt[2];
            MODE_X1: counted = (trans == TR_FWD && prev[2:1] == 2'b01) ||
                               (trans == TR_BWD && prev[2:1] == 2'b11);
            default: counted = 1'b1;
        endcase

        stp_fwd = armed && (trans == TR_FWD) && counted;
        stp_bwd = armed && (trans == TR_BWD) && counted;
        ill     = armed && (trans == TR_ILL);
        idx_ev  = armed && filt[0] && !prev[0];

        count_nxt = count;
        if (load)                          count_nxt = load_val;
        else if (idx_ev && idx_zero_en)    count_nxt = '0;
        else if (stp_fwd)                  count_nxt = count + CNT_W'(1);
        else if (stp_bwd)                  count_nxt = count - CNT_W'(1);

        delta_nxt = delta;
        if (stp_fwd && delta != VMAX)      delta_nxt = delta + VONE;
        else if (stp_bwd && delta != VMIN) delta_nxt = delta - VONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            dir       <= 1'b0;
            step      <= 1'b0;
            idx_cnt   <= '0;
            idx_seen  <= 1'b0;
            err       <= 1'b0;
            vel       <= '0;
            vel_valid <= 1'b0;
            arm_cnt   <= '0;
            wcnt      <= '0;
            delta     <= '0;
        end else begin
            count <= count_nxt;
            if (stp_fwd || stp_bwd) dir <= stp_fwd;
            step <= stp_fwd || stp_bwd;
            if (idx_ev) idx_cnt <= count;

            // a set in the same cycle as status_clr wins
            if (idx_ev)          idx_seen <= 1'b1;
            else if (status_clr) idx_seen <= 1'b0;
            if (ill)             err <= 1'b1;
            else if (status_clr) err <= 1'b0;

            if (!armed) arm_cnt <= arm_cnt + AW'(1);

            vel_valid <= win_end;
            if (win_end) begin
                vel   <= delta_nxt;
                delta <= '0;
                wcnt  <= '0;
            end else begin
                delta <= delta_nxt;
                wcnt  <= wcnt + WW'(1);
            end
        end
    end

endmodule

// File: tb/tb_qei_multimode.sv
// Bench for qei_multimode: directed encoder waveforms, a per-cycle reference model, and literal spot checks.
`timescale 1ns/1ps
module tb_qei_multimode;

    localparam int CNT_W    = 16;
    localparam int FILT_LEN = 3;
    localparam int WIN_CYC  = 64;
    localparam int VEL_W    = 4;
    localparam int CMASK    = (1 << CNT_W) - 1;
    localparam int VSAT     = (1 << (VEL_W - 1)) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enc_a = 1'b0, enc_b = 1'b0, enc_i = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic             idx_zero_en = 1'b0;
    logic             load = 1'b0;
    logic [CNT_W-1:0] load_val = '0;
    logic             status_clr = 1'b0;
    logic [CNT_W-1:0] count;
    logic             dir, step;
    logic [CNT_W-1:0] idx_cnt;
    logic             idx_seen, err;
    logic [VEL_W-1:0] vel;
    logic             vel_valid;

    qei_multimode #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .WIN_CYC(WIN_CYC), .VEL_W(VEL_W)) dut (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_i(enc_i),
        .mode(mode), .idx_zero_en(idx_zero_en), .load(load), .load_val(load_val),
        .status_clr(status_clr), .count(count), .dir(dir), .step(step),
        .idx_cnt(idx_cnt), .idx_seen(idx_seen), .err(err), .vel(vel), .vel_valid(vel_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pins are tracked by position around the quadrature cycle.
    bit [2:0] hist [0:7];
    bit [2:0] mf, mp;
    int  since, wc, delta;
    int  m_count, m_idx, m_vel;
    bit  m_dir, m_step, m_seen, m_err, m_vv;
    bit  started = 0;

    function automatic int pos(input bit [1:0] ab);
        case (ab)
            2'b00: return 0;
            2'b01: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit [2:0] nf;
        bit all_diff, counts, fwd, bwd, ill, idx;
        int d, dl, nc;
        started = 1;
        if (rst) begin
            for (int k = 0; k < 8; k++) hist[k] = '0;
            mf = '0; mp = '0; since = 0; wc = 0; delta = 0;
            m_count = 0; m_idx = 0; m_vel = 0;
            m_dir = 0; m_step = 0; m_seen = 0; m_err = 0; m_vv = 0;
        end else begin
            // a filtered bit flips once the last FILT_LEN synchronised samples all disagree with it
            nf = mf;
            for (int b = 0; b < 3; b++) begin
                all_diff = 1;
                for (int k = 1; k <= FILT_LEN; k++) if (hist[k][b] == mf[b]) all_diff = 0;
                if (all_diff) nf[b] = ~mf[b];
            end
            fwd = 0; bwd = 0; ill = 0; idx = 0;
            if (since >= FILT_LEN + 3) begin
                d = (pos(mf[2:1]) - pos(mp[2:1]) + 4) % 4;
                case (mode)
                    2'b01: counts = (mp[2] != mf[2]);
                    2'b10: counts = (d == 1 && mp[2:1] == 2'b01) || (d == 3 && mp[2:1] == 2'b11);
                    default: counts = 1;
                endcase
                fwd = (d == 1) && counts;
                bwd = (d == 3) && counts;
                ill = (d == 2);
                idx = mf[0] && !mp[0];
            end
            dl = fwd ? 1 : (bwd ? -1 : 0);
            nc = m_count;
            if (dl != 0) nc = (m_count + dl) & CMASK;
            if (idx && idx_zero_en) nc = 0;
            if (load) nc = int'(load_val);
            if (idx) m_idx = m_count;
            m_count = nc;
            if (status_clr) begin m_err = 0; m_seen = 0; end
            if (ill) m_err = 1;
            if (idx) m_seen = 1;
            if (dl != 0) m_dir = (dl > 0);
            m_step = (dl != 0);
            delta = delta + dl;
            if (delta > VSAT) delta = VSAT;
            if (delta < -VSAT) delta = -VSAT;
            m_vv = (wc == WIN_CYC - 1);
            if (m_vv) begin m_vel = delta; delta = 0; end
            wc = (wc + 1) % WIN_CYC;
            mp = mf;
            mf = nf;
            since++;
            for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {enc_a, enc_b, enc_i};
        end
    end

    int nstep = 0;
    int nvv = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("count", count, m_count);
            chk("dir", dir, m_dir);
            chk("step", step, m_step);
            chk("idx_cnt", idx_cnt, m_idx);
            chk("idx_seen", idx_seen, m_seen);
            chk("err", err, m_err);
            chk("vel", $signed(vel), m_vel);
            chk("vel_valid", vel_valid, m_vv);
            if (step === 1'b1) nstep++;
            if (vel_valid === 1'b1) nvv++;
        end
    end

    // Inputs change 2 time units after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int pidx = 0;

    task automatic go_fwd(input int hold);
        pidx = (pidx + 1) % 4;
        {enc_a, enc_b} = seq[pidx];
        tick(hold);
    endtask

    task automatic go_bwd(input int hold);
        pidx = (pidx + 3) % 4;
        {enc_a, enc_b} = seq[pidx];
        tick(hold);
    endtask

    task automatic wait_vv();
        int n = 0;
        @(negedge clk);
        while (vel_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("vel_valid_timeout", 0, 1);
    endtask

    initial begin
        tick(3);
        chk("rst_count", count, 0);
        chk("rst_err", err, 0);
        chk("rst_vel_valid", vel_valid, 0);
        rst = 1'b0;
        tick(10);

        // x4 forward then reverse
        nstep = 0;
        repeat (8) go_fwd(10);
        chk("x4_fwd_count", count, 8);
        chk("x4_fwd_dir", dir, 1);
        chk("x4_fwd_steps", nstep, 8);
        repeat (3) go_bwd(10);
        chk("x4_bwd_count", count, 5);
        chk("x4_bwd_dir", dir, 0);

        // decode modes over full cycles starting from 00
        go_bwd(10);
        chk("to_00_count", count, 4);
        mode = 2'b10; repeat (4) go_fwd(10);
        chk("x1_fwd", count, 5);
        mode = 2'b01; repeat (4) go_fwd(10);
        chk("x2_fwd", count, 7);
        mode = 2'b11; repeat (4) go_fwd(10);
        chk("x4b_fwd", count, 11);
        mode = 2'b10; repeat (4) go_bwd(10);
        chk("x1_bwd", count, 10);
        mode = 2'b00;

        // short glitch filtered out, then an illegal jump 00->11
        enc_a = 1'b1; tick(2); enc_a = 1'b0; tick(10);
        chk("glitch_count", count, 10);
        chk("glitch_err", err, 0);
        enc_a = 1'b1; enc_b = 1'b1; pidx = 2; tick(10);
        chk("ill_count", count, 10);
        chk("ill_err", err, 1);
        status_clr = 1'b1; tick(1); status_clr = 1'b0; tick(1);
        chk("clr_err", err, 0);

        // index with zeroing
        load_val = 16'd37; load = 1'b1; tick(1); load = 1'b0;
        chk("load37", count, 37);
        idx_zero_en = 1'b1; enc_i = 1'b1; tick(5); enc_i = 1'b0; tick(10);
        chk("idxz_cnt", idx_cnt, 37);
        chk("idxz_seen", idx_seen, 1);
        chk("idxz_count", count, 0);

        // index without zeroing
        idx_zero_en = 1'b0;
        load_val = 16'd21; load = 1'b1; status_clr = 1'b1; tick(1); load = 1'b0; status_clr = 1'b0;
        chk("seen_cleared", idx_seen, 0);
        enc_i = 1'b1; tick(5); enc_i = 1'b0; tick(10);
        chk("idx_cnt21", idx_cnt, 21);
        chk("idx_count21", count, 21);
        chk("idx_seen2", idx_seen, 1);

        // wrap both ways
        load_val = 16'hFFFF; load = 1'b1; tick(1); load = 1'b0;
        go_fwd(10);
        chk("wrap_up", count, 0);
        go_bwd(10);
        chk("wrap_down", count, 16'hFFFF);

        // load on the same edge a step decodes (FILT_LEN+3 edges after the pin change)
        go_fwd(5);
        load_val = 16'h1234; load = 1'b1; tick(1); load = 1'b0;
        chk("load_step_count", count, 16'h1234);
        chk("load_step_pulse", step, 1);
        chk("load_step_dir", dir, 1);
        tick(10);

        // reset mid-operation with pins away from 00; arm period hides the jump
        go_fwd(10);
        go_fwd(10);
        chk("pre_rst_count", count, 16'h1236);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("mid_rst_count", count, 0);
        tick(15);
        chk("arm_count", count, 0);
        chk("arm_err", err, 0);

        // velocity windows
        wait_vv(); tick(1);
        repeat (5) go_fwd(4);
        wait_vv();
        chk("vel5", $signed(vel), 5);
        tick(1);
        repeat (10) go_fwd(3);
        wait_vv();
        chk("vel_sat", $signed(vel), 7);
        tick(1);
        wait_vv();
        chk("vel_idle", $signed(vel), 0);
        tick(1);
        nvv = 0; tick(WIN_CYC);
        chk("vv_once", nvv, 1);
        wait_vv(); tick(1);
        repeat (3) go_bwd(4);
        wait_vv();
        chk("vel_neg3", $signed(vel), -3);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
